ex_stage: RTL and testbench

//  Execute stage and EX/MEM pipeline register of the 5-stage MIPS pipeline; consumer of the ID/EX register outputs.

---
 rtl/ex_stage_if.sv | 45 ++++
 rtl/ex_stage.sv | 96 +++++++++
 tb/tb_ex_stage.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled for the ex_stage port.
interface ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              stall_i;
  logic              flush_i;
  logic [1:0]        WB_i;
  logic [1:0]        MEM_i;
  logic              ALU_Src_i;
  logic [1:0]        ALU_OP_i;
  logic              Reg_Dst_i;
  logic [DATA_W-1:0] Reg_data1_i;
  logic [DATA_W-1:0] Reg_data2_i;
  logic [DATA_W-1:0] immd_i;
  logic [REG_AW-1:0] RsAddr_i;
  logic [REG_AW-1:0] RtAddr_i;
  logic [REG_AW-1:0] RdAddr_i;
  logic [REG_AW-1:0] id_RsAddr_i;
  logic [REG_AW-1:0] id_RtAddr_i;
  logic              wb_RegWrite_i;
  logic [REG_AW-1:0] wb_RdAddr_i;
  logic [DATA_W-1:0] wb_data_i;
  logic [1:0]        WB_o;
  logic [1:0]        MEM_o;
  logic [DATA_W-1:0] ALU_result_o;
  logic [DATA_W-1:0] MemWriteData_o;
  logic [REG_AW-1:0] RdAddr_o;
  logic              zero_o;
  logic              hazard_o;

  modport master (
    output stall_i, flush_i, WB_i, MEM_i, ALU_Src_i, ALU_OP_i, Reg_Dst_i,
           Reg_data1_i, Reg_data2_i, immd_i, RsAddr_i, RtAddr_i, RdAddr_i,
           id_RsAddr_i, id_RtAddr_i, wb_RegWrite_i, wb_RdAddr_i, wb_data_i,
    input  WB_o, MEM_o, ALU_result_o, MemWriteData_o, RdAddr_o, zero_o, hazard_o
  );

  modport slave (
    input  stall_i, flush_i, WB_i, MEM_i, ALU_Src_i, ALU_OP_i, Reg_Dst_i,
           Reg_data1_i, Reg_data2_i, immd_i, RsAddr_i, RtAddr_i, RdAddr_i,
           id_RsAddr_i, id_RtAddr_i, wb_RegWrite_i, wb_RdAddr_i, wb_data_i,
    output WB_o, MEM_o, ALU_result_o, MemWriteData_o, RdAddr_o, zero_o, hazard_o
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, destination select, EX/MEM register
// and load-use hazard detection towards ID.
module ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  ex_stage_if.slave  bus
);

  logic [1:0]        wb_q;
  logic [1:0]        mem_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] wdata_q;
  logic [REG_AW-1:0] rd_q;
  logic              zero_q;

  logic              ex_fwd_ok;
  logic              wb_fwd_ok;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic [REG_AW-1:0] dest;

  // A load sitting in EX/MEM has no data yet, so it only forwards later from MEM/WB.
  assign ex_fwd_ok = wb_q[1] && !wb_q[0] && (rd_q != '0);
  assign wb_fwd_ok = bus.wb_RegWrite_i && (bus.wb_RdAddr_i != '0);

  assign op_a  = (ex_fwd_ok && rd_q == bus.RsAddr_i)            ? alu_q :
                 (wb_fwd_ok && bus.wb_RdAddr_i == bus.RsAddr_i) ? bus.wb_data_i :
                                                                  bus.Reg_data1_i;
  assign fwd_b = (ex_fwd_ok && rd_q == bus.RtAddr_i)            ? alu_q :
                 (wb_fwd_ok && bus.wb_RdAddr_i == bus.RtAddr_i) ? bus.wb_data_i :
                                                                  bus.Reg_data2_i;
  assign op_b  = bus.ALU_Src_i ? bus.immd_i : fwd_b;
  assign dest  = bus.Reg_Dst_i ? bus.RdAddr_i : bus.RtAddr_i;

  always_comb begin
    alu_res = '0;
    case (bus.ALU_OP_i)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      2'b11: alu_res = op_a | op_b;
      default: begin
        case (bus.immd_i[5:0])
          6'b100000: alu_res = op_a + op_b;
          6'b100010: alu_res = op_a - op_b;
          6'b100100: alu_res = op_a & op_b;
          6'b100101: alu_res = op_a | op_b;
          6'b101010: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
          6'b011000: alu_res = op_a * op_b;
          default:   alu_res = '0;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_q    <= '0;
      mem_q   <= '0;
      alu_q   <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      zero_q  <= 1'b0;
    end else if (bus.flush_i) begin
      wb_q    <= '0;
      mem_q   <= '0;
      alu_q   <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      zero_q  <= 1'b0;
    end else if (!bus.stall_i) begin
      wb_q    <= bus.WB_i;
      mem_q   <= bus.MEM_i;
      alu_q   <= alu_res;
      wdata_q <= fwd_b;
      rd_q    <= dest;
      zero_q  <= (alu_res == '0);
    end
  end

  assign bus.WB_o           = wb_q;
  assign bus.MEM_o          = mem_q;
  assign bus.ALU_result_o   = alu_q;
  assign bus.MemWriteData_o = wdata_q;
  assign bus.RdAddr_o       = rd_q;
  assign bus.zero_o         = zero_q;

  // Load in EX whose target is read by the instruction now in ID.
  assign bus.hazard_o = bus.MEM_i[1] && (bus.RtAddr_i != '0) &&
                        ((bus.RtAddr_i == bus.id_RsAddr_i) || (bus.RtAddr_i == bus.id_RtAddr_i));

endmodule

// File: tb/tb_ex_stage.sv
// Directed scoreboard bench for ex_stage: expected EX/MEM contents are queued at
// drive time and compared one cycle later.
module tb_ex_stage;

  typedef struct packed {
    logic [1:0]  wb;
    logic [1:0]  mem;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        zero;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t exp_q[$];

  ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] wb, input logic [1:0] mem,
                              input logic [31:0] alu, input logic [31:0] wdata,
                              input logic [4:0] rd, input logic zero);
    exp_t e;
    e.wb = wb; e.mem = mem; e.alu = alu; e.wdata = wdata; e.rd = rd; e.zero = zero;
    return e;
  endfunction

  task automatic apply_stimulus(input logic [1:0] wb, input logic [1:0] mem,
                                input logic [1:0] aluop, input logic src, input logic dst,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
    bus.WB_i = wb; bus.MEM_i = mem; bus.ALU_OP_i = aluop;
    bus.ALU_Src_i = src; bus.Reg_Dst_i = dst;
    bus.RsAddr_i = rs; bus.RtAddr_i = rt; bus.RdAddr_i = rd;
    bus.Reg_data1_i = d1; bus.Reg_data2_i = d2; bus.immd_i = imm;
  endtask

  task automatic wb_port(input logic en, input logic [4:0] rd, input logic [31:0] data);
    bus.wb_RegWrite_i = en; bus.wb_RdAddr_i = rd; bus.wb_data_i = data;
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    tests += 6;
    assert (bus.WB_o === e.wb) else begin
      fails++; $error("[TB] FAIL %s WB_o got %b want %b", tag, bus.WB_o, e.wb); end
    assert (bus.MEM_o === e.mem) else begin
      fails++; $error("[TB] FAIL %s MEM_o got %b want %b", tag, bus.MEM_o, e.mem); end
    assert (bus.ALU_result_o === e.alu) else begin
      fails++; $error("[TB] FAIL %s ALU_result_o got %h want %h", tag, bus.ALU_result_o, e.alu); end
    assert (bus.MemWriteData_o === e.wdata) else begin
      fails++; $error("[TB] FAIL %s MemWriteData_o got %h want %h", tag, bus.MemWriteData_o, e.wdata); end
    assert (bus.RdAddr_o === e.rd) else begin
      fails++; $error("[TB] FAIL %s RdAddr_o got %0d want %0d", tag, bus.RdAddr_o, e.rd); end
    assert (bus.zero_o === e.zero) else begin
      fails++; $error("[TB] FAIL %s zero_o got %b want %b", tag, bus.zero_o, e.zero); end
  endtask

  task automatic clock_step(input string tag, input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_output(tag);
  endtask

  task automatic check_hazard(input string tag, input logic want);
    #1;
    tests++;
    assert (bus.hazard_o === want) else begin
      fails++; $error("[TB] FAIL %s hazard_o got %b want %b", tag, bus.hazard_o, want); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.stall_i = 1'b0; bus.flush_i = 1'b0;
    bus.id_RsAddr_i = '0; bus.id_RtAddr_i = '0;
    wb_port(1'b0, 5'd0, 32'd0);
    apply_stimulus(2'b11, 2'b11, 2'b00, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
    #2;
    exp_q.push_back(mk(2'b00, 2'b00, 32'd0, 32'd0, 5'd0, 1'b0));
    check_output("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back forwarding from EX/MEM into rs and rt
    apply_stimulus(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h20);
    clock_step("add_3", mk(2'b10, 2'b00, 32'd12, 32'd7, 5'd3, 1'b0));
    apply_stimulus(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 5'd3, 5'd1, 5'd4, 32'd0, 32'd5, 32'h22);
    clock_step("sub_fwd_a", mk(2'b10, 2'b00, 32'd7, 32'd5, 5'd4, 1'b0));
    apply_stimulus(2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 5'd4, 5'd0, 32'd1, 32'd0, 32'd0);
    clock_step("fwd_b_exmem", mk(2'b10, 2'b00, 32'd8, 32'd7, 5'd4, 1'b0));

    // EX/MEM beats MEM/WB for the same register; MEM/WB alone is used next
    apply_stimulus(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h20);
    clock_step("add_3_again", mk(2'b10, 2'b00, 32'd12, 32'd7, 5'd3, 1'b0));
    wb_port(1'b1, 5'd3, 32'd99);
    apply_stimulus(2'b10, 2'b00, 2'b11, 1'b0, 1'b1, 5'd3, 5'd0, 5'd5, 32'd0, 32'd0, 32'd0);
    clock_step("double_hazard", mk(2'b10, 2'b00, 32'd12, 32'd0, 5'd5, 1'b0));
    apply_stimulus(2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 5'd3, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0);
    clock_step("wb_only", mk(2'b10, 2'b00, 32'd99, 32'd0, 5'd6, 1'b0));

    // Writes to $0 are never forwarded
    wb_port(1'b0, 5'd0, 32'd0);
    apply_stimulus(2'b10, 2'b00, 2'b00, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd55);
    clock_step("write_r0", mk(2'b10, 2'b00, 32'd55, 32'd0, 5'd0, 1'b0));
    apply_stimulus(2'b10, 2'b00, 2'b11, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0);
    clock_step("read_r0", mk(2'b10, 2'b00, 32'd0, 32'd0, 5'd7, 1'b1));

    // Load-use detection, then a load in EX/MEM must not forward
    apply_stimulus(2'b11, 2'b10, 2'b00, 1'b1, 1'b0, 5'd1, 5'd5, 5'd0, 32'd100, 32'd8, 32'd4);
    bus.id_RsAddr_i = 5'd0; bus.id_RtAddr_i = 5'd5;
    check_hazard("hazard_rt", 1'b1);
    bus.id_RsAddr_i = 5'd2; bus.id_RtAddr_i = 5'd6;
    check_hazard("no_hazard", 1'b0);
    bus.id_RsAddr_i = 5'd5;
    check_hazard("hazard_rs", 1'b1);
    clock_step("lw_5", mk(2'b11, 2'b10, 32'd104, 32'd8, 5'd5, 1'b0));
    bus.id_RsAddr_i = 5'd0; bus.id_RtAddr_i = 5'd0;
    apply_stimulus(2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 5'd5, 5'd0, 5'd8, 32'd1, 32'd0, 32'd0);
    clock_step("no_fwd_from_load", mk(2'b10, 2'b00, 32'd1, 32'd0, 5'd8, 1'b0));

    // Flush wins over stall; stall alone holds
    apply_stimulus(2'b10, 2'b11, 2'b10, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h20);
    bus.stall_i = 1'b1; bus.flush_i = 1'b1;
    clock_step("stall_flush", mk(2'b00, 2'b00, 32'd0, 32'd0, 5'd0, 1'b0));
    bus.stall_i = 1'b0; bus.flush_i = 1'b0;
    apply_stimulus(2'b10, 2'b01, 2'b00, 1'b0, 1'b1, 5'd1, 5'd2, 5'd9, 32'd3, 32'd4, 32'd0);
    clock_step("load_after_flush", mk(2'b10, 2'b01, 32'd7, 32'd4, 5'd9, 1'b0));
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(2'b01, 2'b10, 2'b00, 1'b0, 1'b1, 5'd1, 5'd2, 5'(10 + i), 32'd100 + i, 32'd1, 32'd0);
      clock_step("stall_hold", mk(2'b10, 2'b01, 32'd7, 32'd4, 5'd9, 1'b0));
    end
    bus.stall_i = 1'b0;

    // Funct decode and wrap-around arithmetic
    apply_stimulus(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 5'd1, 5'd2, 5'd10, 32'hFFFF_FFFF, 32'd1, 32'h2a);
    clock_step("slt_signed", mk(2'b10, 2'b00, 32'd1, 32'd1, 5'd10, 1'b0));
    apply_stimulus(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 5'd1, 5'd2, 5'd11, 32'd5, 32'd5, 32'h3f);
    clock_step("bad_funct", mk(2'b10, 2'b00, 32'd0, 32'd5, 5'd11, 1'b1));
    apply_stimulus(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 5'd1, 5'd2, 5'd12, 32'hC, 32'hA, 32'h24);
    clock_step("and", mk(2'b10, 2'b00, 32'h8, 32'hA, 5'd12, 1'b0));
    apply_stimulus(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 5'd1, 5'd2, 5'd13, 32'h0001_0000, 32'h0001_0001, 32'h18);
    clock_step("mul_low", mk(2'b10, 2'b00, 32'h0001_0000, 32'h0001_0001, 5'd13, 1'b0));
    apply_stimulus(2'b10, 2'b00, 2'b01, 1'b0, 1'b1, 5'd1, 5'd2, 5'd15, 32'd3, 32'd5, 32'd0);
    clock_step("sub_wrap", mk(2'b10, 2'b00, 32'hFFFF_FFFE, 32'd5, 5'd15, 1'b0));
    apply_stimulus(2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 5'd1, 5'd2, 5'd14, 32'hFFFF_FFFF, 32'd1, 32'd0);
    clock_step("add_wrap", mk(2'b10, 2'b00, 32'd0, 32'd1, 5'd14, 1'b1));

    // Asynchronous reset between edges while stalled
    apply_stimulus(2'b11, 2'b11, 2'b10, 1'b1, 1'b1, 5'd7, 5'd8, 5'd9, 32'd11, 32'd22, 32'h20);
    wb_port(1'b1, 5'd7, 32'd33);
    bus.stall_i = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(2'b00, 2'b00, 32'd0, 32'd0, 5'd0, 1'b0));
    check_output("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    bus.stall_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
